mips_control_fsm: RTL and testbench

//  Main control unit of the multi-cycle, non-pipelined MIPS core; directly upstream of the register file.

---
 rtl/mips_control_fsm_if.sv | 36 +++
 rtl/mips_control_fsm.sv | 196 +++++++++++++++++++
 tb/tb_mips_control_fsm.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_control_fsm_if.sv
// Control bundle between the multi-cycle MIPS control FSM (master) and the datapath (slave).
// The master modport is the FSM side: it reads instruction fields and the ALU flag, and drives all selects/enables.
interface mips_control_fsm_if #(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6,
  parameter int STATE_WIDTH = 4
);
  logic [OP_WIDTH-1:0]    op;
  logic [FUNCT_WIDTH-1:0] funct;
  logic                   zero;
  logic                   IorD;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   RegDst;
  logic                   MemtoReg;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [2:0]             ALUControl;
  logic [1:0]             PCSrc;
  logic                   PCEn;
  logic                   illegal_op;
  logic [STATE_WIDTH-1:0] state_o;

  modport master (
    input  op, funct, zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, PCEn, illegal_op, state_o
  );

  modport slave (
    output op, funct, zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, PCEn, illegal_op, state_o
  );
endinterface

// File: rtl/mips_control_fsm.sv
// Moore control FSM of the multi-cycle MIPS core: sequences LW/SW/R-type/BEQ/ADDI/J and drives datapath controls.
// Per-state controls are registered together with the state; write enables are additionally gated by rst_n.
module mips_control_fsm #(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6,
  parameter int STATE_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mips_control_fsm_if.master  bus
);

  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       in_decode;
  } ctrl_t;

  localparam logic [OP_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_WIDTH-1:0] OP_J     = 6'b000010;

  state_e state_r;
  state_e state_nx_s;
  ctrl_t  ctrl_r;
  logic   op_legal_s;

  function automatic logic is_legal(input logic [OP_WIDTH-1:0] op_v);
    logic ok;
    case (op_v)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic state_e next_state(input state_e s, input logic [OP_WIDTH-1:0] op_v);
    state_e n;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (op_v)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_EXECUTE;
          OP_BEQ:       n = S_BRANCH;
          OP_ADDI:      n = S_ADDIEXEC;
          OP_J:         n = S_JUMP;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (op_v)
          OP_LW:   n = S_MEMRD;
          OP_SW:   n = S_MEMWR;
          default: n = S_FETCH;
        endcase
      end
      S_MEMRD:    n = S_MEMWB;
      S_EXECUTE:  n = S_ALUWB;
      S_ADDIEXEC: n = S_ADDIWB;
      default:    n = S_FETCH;  // terminal states and unused codes 12-15
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.in_decode = 1'b1;
      end
      S_MEMADR, S_ADDIEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDIWB:  c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_decode(input logic [1:0] alu_op, input logic [FUNCT_WIDTH-1:0] f);
    logic [2:0] ctl;
    case (alu_op)
      2'b01: ctl = 3'b110;
      2'b10: begin
        case (f)
          6'b100000: ctl = 3'b010;
          6'b100010: ctl = 3'b110;
          6'b100100: ctl = 3'b000;
          6'b100101: ctl = 3'b001;
          6'b101010: ctl = 3'b111;
          default:   ctl = 3'b010;
        endcase
      end
      default: ctl = 3'b010;
    endcase
    return ctl;
  endfunction

  // Next-state and opcode legality from the current state and instruction fields.
  always_comb begin
    state_nx_s = next_state(state_r, bus.op);
    op_legal_s = is_legal(bus.op);
  end

  // State register with the matching Moore controls loaded alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      ctrl_r  <= decode_state(S_FETCH);
    end else begin
      state_r <= state_nx_s;
      ctrl_r  <= decode_state(state_nx_s);
    end
  end

  // Enables that change architectural state are forced low the moment reset asserts.
  assign bus.IRWrite    = ctrl_r.ir_write  & rst_n;
  assign bus.RegWrite   = ctrl_r.reg_write & rst_n;
  assign bus.MemWrite   = ctrl_r.mem_write & rst_n;
  assign bus.PCEn       = rst_n & (ctrl_r.pc_write | (ctrl_r.branch & bus.zero));
  assign bus.illegal_op = rst_n & ctrl_r.in_decode & ~op_legal_s;

  assign bus.IorD       = ctrl_r.iord;
  assign bus.RegDst     = ctrl_r.reg_dst;
  assign bus.MemtoReg   = ctrl_r.mem_to_reg;
  assign bus.ALUSrcA    = ctrl_r.alu_src_a;
  assign bus.ALUSrcB    = ctrl_r.alu_src_b;
  assign bus.PCSrc      = ctrl_r.pc_src;
  assign bus.ALUControl = alu_decode(ctrl_r.alu_op, bus.funct);
  assign bus.state_o    = state_r;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: walks every instruction class, the ALU decoder, illegal ops and mid-instruction reset.
module tb_mips_control_fsm;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   failed;

  mips_control_fsm_if #(.OP_WIDTH(6), .FUNCT_WIDTH(6), .STATE_WIDTH(4)) bus ();

  mips_control_fsm #(.OP_WIDTH(6), .FUNCT_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled mid-cycle on the falling edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic run_rtype(input logic [5:0] f, input logic [2:0] exp_alu);
    bus.op = 6'b000000; bus.funct = f;
    check("r_fetch", bus.state_o, 32'd0);
    next_cycle(); check("r_decode", bus.state_o, 32'd1);
    next_cycle(); check("r_exec", bus.state_o, 32'd6);
    check("r_aluctl", bus.ALUControl, exp_alu);
    check("r_exec_srcb", bus.ALUSrcB, 32'd0);
    check("r_exec_regwr", bus.RegWrite, 32'd0);
    next_cycle(); check("r_aluwb", bus.state_o, 32'd7);
    check("r_regdst", bus.RegDst, 32'd1);
    check("r_regwr", bus.RegWrite, 32'd1);
    next_cycle(); check("r_back", bus.state_o, 32'd0);
  endtask

  task automatic run_beq(input logic z);
    bus.op = 6'b000100; bus.zero = z;
    next_cycle(); check("beq_decode", bus.state_o, 32'd1);
    next_cycle(); check("beq_branch", bus.state_o, 32'd8);
    check("beq_pcen", bus.PCEn, {31'd0, z});
    check("beq_pcsrc", bus.PCSrc, 32'd1);
    check("beq_aluctl", bus.ALUControl, 32'd6);
    check("beq_regwr", bus.RegWrite, 32'd0);
    next_cycle(); check("beq_back", bus.state_o, 32'd0);
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    rst_n     = 1'b0;
    bus.op    = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("rst_state", bus.state_o, 32'd0);
      check("rst_irwrite", bus.IRWrite, 32'd0);
      check("rst_pcen", bus.PCEn, 32'd0);
    end
    check("rst_srcb", bus.ALUSrcB, 32'd1);
    rst_n = 1'b1;
    #1;
    check("rel_irwrite", bus.IRWrite, 32'd1);
    check("rel_pcen", bus.PCEn, 32'd1);
    check("rel_aluctl", bus.ALUControl, 32'd2);

    // LW: 0,1,2,3,4,0
    bus.op = 6'b100011;
    next_cycle(); check("lw_decode", bus.state_o, 32'd1);
    check("lw_dec_srcb", bus.ALUSrcB, 32'd3);
    check("lw_dec_ill", bus.illegal_op, 32'd0);
    next_cycle(); check("lw_memadr", bus.state_o, 32'd2);
    check("lw_srca", bus.ALUSrcA, 32'd1);
    check("lw_srcb", bus.ALUSrcB, 32'd2);
    next_cycle(); check("lw_memrd", bus.state_o, 32'd3);
    check("lw_iord", bus.IorD, 32'd1);
    check("lw_rd_regwr", bus.RegWrite, 32'd0);
    check("lw_rd_m2r", bus.MemtoReg, 32'd0);
    next_cycle(); check("lw_memwb", bus.state_o, 32'd4);
    check("lw_regwr", bus.RegWrite, 32'd1);
    check("lw_m2r", bus.MemtoReg, 32'd1);
    check("lw_regdst", bus.RegDst, 32'd0);
    next_cycle(); check("lw_back", bus.state_o, 32'd0);
    check("lw_back_regwr", bus.RegWrite, 32'd0);

    // R-type through the ALU decoder.
    run_rtype(6'b101010, 3'b111);
    run_rtype(6'b100010, 3'b110);
    run_rtype(6'b100100, 3'b000);
    run_rtype(6'b100101, 3'b001);
    run_rtype(6'b111111, 3'b010);

    // BEQ taken and not taken.
    run_beq(1'b1);
    run_beq(1'b0);

    // SW: 0,1,2,5,0
    bus.op = 6'b101011;
    next_cycle(); check("sw_decode", bus.state_o, 32'd1);
    next_cycle(); check("sw_memadr", bus.state_o, 32'd2);
    next_cycle(); check("sw_memwr", bus.state_o, 32'd5);
    check("sw_memwrite", bus.MemWrite, 32'd1);
    check("sw_iord", bus.IorD, 32'd1);
    check("sw_regwr", bus.RegWrite, 32'd0);
    next_cycle(); check("sw_back", bus.state_o, 32'd0);
    check("sw_back_mw", bus.MemWrite, 32'd0);

    // ADDI: 0,1,9,10,0
    bus.op = 6'b001000;
    next_cycle(); check("addi_decode", bus.state_o, 32'd1);
    next_cycle(); check("addi_exec", bus.state_o, 32'd9);
    check("addi_srcb", bus.ALUSrcB, 32'd2);
    check("addi_aluctl", bus.ALUControl, 32'd2);
    next_cycle(); check("addi_wb", bus.state_o, 32'd10);
    check("addi_regwr", bus.RegWrite, 32'd1);
    check("addi_regdst", bus.RegDst, 32'd0);
    check("addi_m2r", bus.MemtoReg, 32'd0);
    next_cycle(); check("addi_back", bus.state_o, 32'd0);

    // J: 0,1,11,0
    bus.op = 6'b000010;
    next_cycle(); check("j_decode", bus.state_o, 32'd1);
    check("j_dec_pcen", bus.PCEn, 32'd0);
    next_cycle(); check("j_jump", bus.state_o, 32'd11);
    check("j_pcsrc", bus.PCSrc, 32'd2);
    check("j_pcen", bus.PCEn, 32'd1);
    next_cycle(); check("j_back", bus.state_o, 32'd0);

    // Illegal opcode: one-cycle pulse in DECODE only.
    bus.op = 6'b111111;
    check("ill_fetch", bus.illegal_op, 32'd0);
    next_cycle(); check("ill_decode", bus.state_o, 32'd1);
    check("ill_pulse", bus.illegal_op, 32'd1);
    check("ill_regwr", bus.RegWrite, 32'd0);
    check("ill_memwr", bus.MemWrite, 32'd0);
    next_cycle(); check("ill_back", bus.state_o, 32'd0);
    check("ill_clear", bus.illegal_op, 32'd0);
    check("ill_back_regwr", bus.RegWrite, 32'd0);

    // Reset asserted during MEMWB of a load.
    bus.op = 6'b100011;
    next_cycle(); next_cycle(); next_cycle(); next_cycle();
    check("rlw_memwb", bus.state_o, 32'd4);
    check("rlw_regwr_pre", bus.RegWrite, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rlw_state", bus.state_o, 32'd0);
    check("rlw_regwr", bus.RegWrite, 32'd0);
    check("rlw_irwrite", bus.IRWrite, 32'd0);
    next_cycle();
    check("rlw_hold", bus.state_o, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rlw_refetch_ir", bus.IRWrite, 32'd1);
    next_cycle(); check("rlw_decode", bus.state_o, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
